// File: rtl/rom_dtack_sequencer.sv
// ROM DTACK sequencer for a 68000 bus.
// Generates DTACK for ROM accesses after a configurable number of wait
// states. Also provides a bus-error watchdog that drives BERR when an access
// stays unacknowledged for too long.
// Both bus lines are open-drive style: a level plus a drive enable.
module rom_dtack_sequencer #(
    parameter int TIMEOUT = 128,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       as_n_i,
    input  logic       rom_ce_n_i,
    input  logic [2:0] wait_cfg_i,
    input  logic       ext_dtack_n_i,
    input  logic       vpa_n_i,
    output logic       dtack_o,
    output logic       dtack_oe_o,
    output logic       berr_o,
    output logic       berr_oe_o,
    output logic       busy_o
);

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WD_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WD_ZERO  = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ASSERT  = 2'd2,
        S_RELEASE = 2'd3
    } dtack_state_e;

    typedef enum logic [1:0] {
        B_IDLE    = 2'd0,
        B_ASSERT  = 2'd1,
        B_RELEASE = 2'd2
    } berr_state_e;

    dtack_state_e     dstate_q, dstate_d;
    berr_state_e      bstate_q, bstate_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             ack_s;
    logic             wd_hit_s;
    logic             dtack_q, dtack_d;
    logic             dtack_oe_q, dtack_oe_d;
    logic             berr_q, berr_d;
    logic             berr_oe_q, berr_oe_d;
    logic             busy_q, busy_d;

    assign dtack_o    = dtack_q;
    assign dtack_oe_o = dtack_oe_q;
    assign berr_o     = berr_q;
    assign berr_oe_o  = berr_oe_q;
    assign busy_o     = busy_q;

    // DTACK FSM next state and wait-state counter (config captured only in IDLE)
    always_comb begin
        dstate_d   = dstate_q;
        wait_cnt_d = wait_cnt_q;
        case (dstate_q)
            S_IDLE: begin
                if (!rom_ce_n_i) begin
                    wait_cnt_d = wait_cfg_i;
                    if (wait_cfg_i == 3'd0) begin
                        dstate_d = S_ASSERT;
                    end else begin
                        dstate_d = S_WAIT;
                    end
                end else begin
                    dstate_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (rom_ce_n_i) begin
                    // Aborted access: CPU dropped the chip enable before DTACK
                    dstate_d   = S_IDLE;
                    wait_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                    // A zero count here is treated like 1 so a corrupted counter cannot stall
                    if (wait_cnt_q <= 3'd1) begin
                        dstate_d = S_ASSERT;
                    end else begin
                        dstate_d = S_WAIT;
                    end
                end
            end
            S_ASSERT: begin
                if (rom_ce_n_i) begin
                    dstate_d = S_RELEASE;
                end else begin
                    dstate_d = S_ASSERT;
                end
            end
            S_RELEASE: begin
                dstate_d = S_IDLE;
            end
            default: begin
                dstate_d   = S_IDLE;
                wait_cnt_d = 3'd0;
            end
        endcase
    end

    // Watchdog: clears when AS is high, counts unacknowledged cycles, saturates at the limit
    always_comb begin
        // Entering ASSERT counts as an acknowledge so DTACK wins a same-edge race
        ack_s = (~ext_dtack_n_i) | (~vpa_n_i) |
                (dstate_q == S_ASSERT) | (dstate_d == S_ASSERT);
        if (as_n_i) begin
            wd_d = WD_ZERO;
        end else if (!ack_s && (wd_q < WD_LIMIT)) begin
            wd_d = wd_q + WD_ONE;
        end else begin
            wd_d = wd_q;
        end
        wd_hit_s = (wd_d == WD_LIMIT) && (wd_q != WD_LIMIT);
    end

    // BERR FSM next state and its registered drive values
    always_comb begin
        bstate_d = bstate_q;
        case (bstate_q)
            B_IDLE: begin
                if (wd_hit_s) begin
                    bstate_d = B_ASSERT;
                end else begin
                    bstate_d = B_IDLE;
                end
            end
            B_ASSERT: begin
                if (as_n_i) begin
                    bstate_d = B_RELEASE;
                end else begin
                    bstate_d = B_ASSERT;
                end
            end
            B_RELEASE: begin
                bstate_d = B_IDLE;
            end
            default: begin
                bstate_d = B_IDLE;
            end
        endcase

        case (bstate_d)
            B_ASSERT: begin
                berr_oe_d = 1'b1;
                berr_d    = 1'b0;
            end
            B_RELEASE: begin
                berr_oe_d = 1'b1;
                berr_d    = 1'b1;
            end
            default: begin
                berr_oe_d = 1'b0;
                berr_d    = 1'b1;
            end
        endcase
    end

    // DTACK drive values: low while held in ASSERT, one high-drive cycle on release
    always_comb begin
        dtack_oe_d = 1'b0;
        dtack_d    = 1'b1;
        busy_d     = (dstate_d != S_IDLE);
        if (dstate_q == S_ASSERT) begin
            if (rom_ce_n_i) begin
                dtack_oe_d = 1'b1;
                dtack_d    = 1'b1;
            end else if (bstate_d == B_IDLE) begin
                dtack_oe_d = 1'b1;
                dtack_d    = 1'b0;
            end else begin
                // A bus error is in progress: never pull DTACK low alongside BERR
                dtack_oe_d = 1'b0;
                dtack_d    = 1'b1;
            end
        end else begin
            dtack_oe_d = 1'b0;
            dtack_d    = 1'b1;
        end
    end

    // State, counters and registered outputs; reset releases both lines at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_q   <= S_IDLE;
            bstate_q   <= B_IDLE;
            wait_cnt_q <= 3'd0;
            wd_q       <= WD_ZERO;
            dtack_q    <= 1'b1;
            dtack_oe_q <= 1'b0;
            berr_q     <= 1'b1;
            berr_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dstate_q   <= dstate_d;
            bstate_q   <= bstate_d;
            wait_cnt_q <= wait_cnt_d;
            wd_q       <= wd_d;
            dtack_q    <= dtack_d;
            dtack_oe_q <= dtack_oe_d;
            berr_q     <= berr_d;
            berr_oe_q  <= berr_oe_d;
            busy_q     <= busy_d;
        end
    end

endmodule
